ad7760_seq: RTL and testbench

AD7760_SEQ -- requirements
Module: ad7760_seq

---
 rtl/ad7760_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_ad7760_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ad7760_seq.sv
// AD7760 bring-up sequencer: pulses the ADC reset, writes both control registers
// over the parallel bus, then captures one sample per data-ready falling edge.
module ad7760_seq #(
    parameter int          RST_LOW_CYC  = 2,
    parameter int          RST_HIGH_CYC = 3,
    parameter int          WR_CS_CYC    = 8,
    parameter int          WR_GAP_CYC   = 8,
    parameter int          POST_CFG_CYC = 6,
    parameter logic [15:0] CTRL1_VAL    = 16'h0000,
    parameter logic [15:0] CTRL2_VAL    = 16'h0022
) (
    input  logic        mclk,
    input  logic        i_rest_n,
    input  logic        command,
    input  logic        drdy_n,
    input  logic [15:0] adc_din,
    output logic        o_rest_n,
    output logic        cs_n,
    output logic        r_n_w,
    output logic [15:0] adc_dout,
    output logic        adc_oe,
    output logic [15:0] sample_data,
    output logic        sample_valid,
    input  logic        fifo_full,
    output logic        cfg_done,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RST_LO    = 4'd1,
        RST_HI    = 4'd2,
        WR_ADR    = 4'd3,
        GAP_ADR   = 4'd4,
        WR_VAL    = 4'd5,
        GAP_VAL   = 4'd6,
        POST_WAIT = 4'd7,
        ACQ       = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic        reg_idx_q, reg_idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] len_s;
    logic        last_s;

    logic        sync1_q, sync2_q, sync3_q;
    logic        fall_s, cap_s;

    logic        o_rest_n_q, o_rest_n_d;
    logic        cs_n_q, cs_n_d;
    logic        r_n_w_q, r_n_w_d;
    logic [15:0] adc_dout_q, adc_dout_d;
    logic        adc_oe_q, adc_oe_d;
    logic        cfg_done_q, cfg_done_d;
    logic [15:0] sample_data_q, sample_data_d;
    logic        sample_valid_q, sample_valid_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    // Dwell length of the current timed state
    always_comb begin
        len_s = 16'd1;
        case (state_q)
            RST_LO:            len_s = 16'(RST_LOW_CYC);
            RST_HI:            len_s = 16'(RST_HIGH_CYC);
            WR_ADR, WR_VAL:    len_s = 16'(WR_CS_CYC);
            GAP_ADR, GAP_VAL:  len_s = 16'(WR_GAP_CYC);
            POST_WAIT:         len_s = 16'(POST_CFG_CYC);
            default:           len_s = 16'd1;
        endcase
        last_s = (cnt_q == (len_s - 16'd1));
    end

    // Next-state logic; command is only honoured in IDLE, POST_WAIT exit and ACQ
    always_comb begin
        state_d   = state_q;
        reg_idx_d = reg_idx_q;
        cnt_d     = 16'd0;
        case (state_q)
            IDLE: begin
                if (command) begin
                    state_d   = RST_LO;
                    reg_idx_d = 1'b0;
                end else begin
                    state_d   = IDLE;
                end
            end
            RST_LO, RST_HI, WR_ADR, GAP_ADR, WR_VAL, GAP_VAL, POST_WAIT: begin
                if (last_s) begin
                    cnt_d = 16'd0;
                    case (state_q)
                        RST_LO:  state_d = RST_HI;
                        RST_HI:  state_d = WR_ADR;
                        WR_ADR:  state_d = GAP_ADR;
                        GAP_ADR: state_d = WR_VAL;
                        WR_VAL:  state_d = GAP_VAL;
                        GAP_VAL: begin
                            if (!reg_idx_q) begin
                                state_d   = WR_ADR;
                                reg_idx_d = 1'b1;
                            end else begin
                                state_d   = POST_WAIT;
                            end
                        end
                        POST_WAIT: state_d = command ? ACQ : IDLE;
                        default:   state_d = IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ACQ: begin
                if (!command) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs decoded from the upcoming state so the registered pins line up with it
    always_comb begin
        o_rest_n_d = 1'b1;
        cs_n_d     = 1'b1;
        r_n_w_d    = 1'b1;
        adc_oe_d   = 1'b0;
        adc_dout_d = 16'h0000;
        cfg_done_d = 1'b0;
        case (state_d)
            RST_LO: o_rest_n_d = 1'b0;
            WR_ADR: begin
                cs_n_d     = 1'b0;
                adc_oe_d   = 1'b1;
                adc_dout_d = reg_idx_d ? 16'h0002 : 16'h0001;
            end
            WR_VAL: begin
                cs_n_d     = 1'b0;
                adc_oe_d   = 1'b1;
                adc_dout_d = reg_idx_d ? CTRL2_VAL : CTRL1_VAL;
            end
            ACQ: begin
                cs_n_d     = 1'b0;
                r_n_w_d    = 1'b0;
                cfg_done_d = 1'b1;
            end
            default: o_rest_n_d = 1'b1;
        endcase
    end

    // Sample capture; an edge coinciding with the ACQ exit is discarded
    always_comb begin
        fall_s         = sync3_q & ~sync2_q;
        cap_s          = (state_q == ACQ) & command & fall_s;
        sample_data_d  = sample_data_q;
        sample_valid_d = 1'b0;
        drop_cnt_d     = drop_cnt_q;
        if (cap_s) begin
            if (fifo_full) begin
                if (drop_cnt_q != 8'd255) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end else begin
                    drop_cnt_d = drop_cnt_q;
                end
            end else begin
                sample_data_d  = adc_din;
                sample_valid_d = 1'b1;
            end
        end else begin
            sample_valid_d = 1'b0;
        end
    end

    // State, synchronizer and output registers with synchronous active-low reset
    always_ff @(posedge mclk) begin
        if (!i_rest_n) begin
            state_q        <= IDLE;
            reg_idx_q      <= 1'b0;
            cnt_q          <= 16'd0;
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            sync3_q        <= 1'b1;
            o_rest_n_q     <= 1'b1;
            cs_n_q         <= 1'b1;
            r_n_w_q        <= 1'b1;
            adc_dout_q     <= 16'h0000;
            adc_oe_q       <= 1'b0;
            cfg_done_q     <= 1'b0;
            sample_data_q  <= 16'h0000;
            sample_valid_q <= 1'b0;
            drop_cnt_q     <= 8'd0;
        end else begin
            state_q        <= state_d;
            reg_idx_q      <= reg_idx_d;
            cnt_q          <= cnt_d;
            sync1_q        <= drdy_n;
            sync2_q        <= sync1_q;
            sync3_q        <= sync2_q;
            o_rest_n_q     <= o_rest_n_d;
            cs_n_q         <= cs_n_d;
            r_n_w_q        <= r_n_w_d;
            adc_dout_q     <= adc_dout_d;
            adc_oe_q       <= adc_oe_d;
            cfg_done_q     <= cfg_done_d;
            sample_data_q  <= sample_data_d;
            sample_valid_q <= sample_valid_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    assign o_rest_n     = o_rest_n_q;
    assign cs_n         = cs_n_q;
    assign r_n_w        = r_n_w_q;
    assign adc_dout     = adc_dout_q;
    assign adc_oe       = adc_oe_q;
    assign cfg_done     = cfg_done_q;
    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_ad7760_seq.sv
// Randomized bench for ad7760_seq against a timeline/queue reference model,
// checked every cycle plus scenario-level latency and count checks.
module tb_ad7760_seq;

    logic        mclk = 1'b0;
    logic        i_rest_n = 1'b0;
    logic        command = 1'b0;
    logic        drdy_n = 1'b1;
    logic [15:0] adc_din = 16'h0000;
    logic        fifo_full = 1'b0;
    logic        o_rest_n, cs_n, r_n_w, adc_oe, sample_valid, cfg_done;
    logic [15:0] adc_dout, sample_data;
    logic [7:0]  drop_cnt;

    ad7760_seq dut (
        .mclk(mclk), .i_rest_n(i_rest_n), .command(command), .drdy_n(drdy_n),
        .adc_din(adc_din), .o_rest_n(o_rest_n), .cs_n(cs_n), .r_n_w(r_n_w),
        .adc_dout(adc_dout), .adc_oe(adc_oe), .sample_data(sample_data),
        .sample_valid(sample_valid), .fifo_full(fifo_full), .cfg_done(cfg_done),
        .drop_cnt(drop_cnt)
    );

    always #5 mclk = ~mclk;

    localparam int M_IDLE = 0, M_CFG = 1, M_ACQ = 2;
    localparam int T_RST_END = 2, T_WR_START = 5, T_WR_END = 69, T_LAST = 74;
    logic [15:0] wr_tbl [4] = '{16'h0001, 16'h0000, 16'h0002, 16'h0022};

    int n_checks = 0, n_errors = 0;
    int mode = M_IDLE, t = 0, m_drop = 0;
    logic [15:0] m_data = 16'h0000;
    logic m_valid = 1'b0;
    logic hist [$];
    bit rst_seen = 1'b0;
    int valid_seen = 0, done_seen = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: position in the configuration timeline plus the drdy_n sample history
    task automatic model_edge();
        logic fall;
        int n;
        n = hist.size();
        fall = (n >= 3) && (hist[n-2] == 1'b0) && (hist[n-3] == 1'b1);
        m_valid = 1'b0;
        if (!i_rest_n) begin
            rst_seen = 1'b1;
            mode = M_IDLE; t = 0; m_drop = 0; m_data = 16'h0000;
            hist = {1'b1, 1'b1, 1'b1};
        end else begin
            case (mode)
                M_IDLE: if (command) begin mode = M_CFG; t = 0; end
                M_CFG: begin
                    if (t == T_LAST) mode = command ? M_ACQ : M_IDLE;
                    else t++;
                end
                default: begin
                    if (!command) mode = M_IDLE;
                    else if (fall) begin
                        if (fifo_full) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                        else begin m_data = adc_din; m_valid = 1'b1; end
                    end
                end
            endcase
            hist.push_back(drdy_n);
            if (hist.size() > 8) void'(hist.pop_front());
        end
    endtask

    task automatic check_outputs();
        logic pulse, e_orn;
        logic [15:0] e_dout;
        int u;
        pulse = 1'b0; e_orn = 1'b1; e_dout = 16'h0000;
        if (mode == M_CFG) begin
            if (t < T_RST_END) e_orn = 1'b0;
            if (t >= T_WR_START && t < T_WR_END) begin
                u = t - T_WR_START;
                if ((u % 16) < 8) begin pulse = 1'b1; e_dout = wr_tbl[u / 16]; end
            end
        end
        check("o_rest_n", 16'(o_rest_n), 16'(e_orn));
        check("cs_n", 16'(cs_n), 16'(!(pulse || mode == M_ACQ)));
        check("r_n_w", 16'(r_n_w), 16'(mode != M_ACQ));
        check("adc_oe", 16'(adc_oe), 16'(pulse));
        check("adc_dout", adc_dout, e_dout);
        check("cfg_done", 16'(cfg_done), 16'(mode == M_ACQ));
        check("sample_valid", 16'(sample_valid), 16'(m_valid));
        check("sample_data", sample_data, m_data);
        check("drop_cnt", 16'(drop_cnt), 16'(m_drop));
    endtask

    task automatic tick();
        @(posedge mclk);
        model_edge();
        @(negedge mclk);
        if (rst_seen) check_outputs();
        if (sample_valid) valid_seen++;
        if (cfg_done) done_seen++;
    endtask

    task automatic run_until_done(output int n);
        n = 0;
        do begin tick(); n++; end while (!cfg_done && n < 200);
    endtask

    task automatic pulse(input int len, input logic [15:0] din);
        adc_din = din;
        drdy_n = 1'b0;
        repeat (len) tick();
        drdy_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        int lat, v0, d0;
        repeat (3) tick();
        i_rest_n = 1'b1;
        repeat (4) tick();

        // Full configuration, then first ACQ cycle
        command = 1'b1;
        run_until_done(lat);
        check("cfg_latency", 16'(lat), 16'd76);

        // Single capture with timing of the strobe
        repeat (3) tick();
        v0 = valid_seen;
        adc_din = 16'hA5C3;
        drdy_n = 1'b0;
        tick(); tick();
        check("cap_early", 16'(sample_valid), 16'd0);
        tick();
        check("cap_valid", 16'(sample_valid), 16'd1);
        check("cap_data", sample_data, 16'hA5C3);
        tick();
        drdy_n = 1'b1;
        adc_din = 16'h0000;
        repeat (4) tick();
        check("cap_count", 16'(valid_seen - v0), 16'd1);

        // Random pulses with random back-pressure
        for (int i = 0; i < 30; i++) begin
            fifo_full = 1'($urandom_range(0, 2) == 0);
            pulse($urandom_range(1, 6), 16'($urandom));
        end

        // Overflow saturation, then recovery
        fifo_full = 1'b1;
        v0 = valid_seen;
        for (int i = 0; i < 300; i++) pulse(1, 16'($urandom));
        check("ovf_drop", 16'(drop_cnt), 16'd255);
        check("ovf_novalid", 16'(valid_seen - v0), 16'd0);
        fifo_full = 1'b0;
        pulse(2, 16'h1234);
        check("ovf_recover", 16'(valid_seen - v0), 16'd1);
        check("ovf_drop_hold", 16'(drop_cnt), 16'd255);

        // Stop in ACQ coinciding with a detected edge
        v0 = valid_seen;
        drdy_n = 1'b0;
        adc_din = 16'hBEEF;
        tick(); tick();
        command = 1'b0;
        tick();
        check("stop_idle", 16'(cfg_done), 16'd0);
        drdy_n = 1'b1;
        repeat (3) tick();
        check("stop_nocap", 16'(valid_seen - v0), 16'd0);

        // Stop requested during the second value write: sequence completes, no ACQ
        command = 1'b1;
        tick();
        repeat (55) tick();
        command = 1'b0;
        d0 = done_seen;
        for (int i = 0; i < 100; i++) begin
            drdy_n = 1'($urandom_range(0, 1));
            tick();
        end
        drdy_n = 1'b1;
        check("late_stop_done", 16'(done_seen - d0), 16'd0);
        check("late_stop_cs", 16'(cs_n), 16'd1);

        // Reset in the middle of the first address write, command held
        command = 1'b1;
        repeat (9) tick();
        i_rest_n = 1'b0;
        tick();
        check("mid_rst_cs", 16'(cs_n), 16'd1);
        check("mid_rst_oe", 16'(adc_oe), 16'd0);
        check("mid_rst_drop", 16'(drop_cnt), 16'd0);
        check("mid_rst_data", sample_data, 16'h0000);
        i_rest_n = 1'b1;
        run_until_done(lat);
        check("restart_latency", 16'(lat), 16'd76);

        for (int i = 0; i < 10; i++) pulse($urandom_range(1, 4), 16'($urandom));
        command = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
